// File: rtl/fp_mult_arbiter_pkg.sv
// Shared constants for the FP multiplier arbiter: sequencer states,
// multiplier state codes and the operand width helper.
package fp_mult_arbiter_pkg;

  localparam logic [1:0] ARB    = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] BUSY   = 2'd2;
  localparam logic [1:0] RESULT = 2'd3;

  localparam logic [1:0] FPM_IDLE      = 2'd0;
  localparam logic [1:0] FPM_COMPUTING = 2'd1;
  localparam logic [1:0] FPM_POST      = 2'd2;

  function automatic int fpmWidth(input int mbits, input int ebits);
    return mbits + ebits + 1;
  endfunction

endpackage

// File: rtl/fp_mult_arbiter_picker.sv
// Combinational round-robin picker: first requester at or after ptr,
// found by scanning a doubled request vector over the window [ptr, ptr+NREQ).
module fpm_rr_picker
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
)
(
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gidx,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;
  int pos;

  // Scanning downward lets the lowest in-window hit overwrite earlier ones.
  always_comb begin
    dbl   = {req, req};
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    pos   = 0;
    for (int j = 2*NREQ-1; j >= 0; j--) begin
      if (dbl[j] && (j >= int'(ptr)) && (j < int'(ptr) + NREQ)) begin
        pos        = (j >= NREQ) ? j - NREQ : j;
        grant      = '0;
        grant[pos] = 1'b1;
        gidx       = IDW'(pos);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Round-robin sequencer sharing one external 3-cycle FP multiplier among
// NREQ requesters; returns each product tagged with its requester index.
module fp_mult_arbiter
  import fp_mult_arbiter_pkg::*;
#(
  parameter int MBITS = 3,
  parameter int EBITS = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  localparam int W    = fpmWidth(MBITS, EBITS)
)
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] opa,
  input  logic [NREQ*W-1:0] opb,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [W-1:0]      res_z,
  output logic              fpm_start,
  output logic [W-1:0]      fpm_x,
  output logic [W-1:0]      fpm_y,
  input  logic [1:0]        fpm_state,
  input  logic [W-1:0]      fpm_z
);

  logic [1:0]      state;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic            any;
  logic            grantNow;

  fpm_rr_picker #(.NREQ(NREQ), .IDW(IDW)) picker (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .gidx  (gidx),
    .any   (any)
  );

  // The multiplier has no reset, so a grant also waits for it to drain.
  assign grantNow  = reset_n && (state == ARB) && (fpm_state == FPM_IDLE) && any;
  assign ack       = grantNow ? grant : '0;
  assign busy      = (state != ARB);
  assign fpm_start = (state == ISSUE);
  assign res_valid = (state == RESULT);
  assign res_z     = fpm_z;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ARB;
      ptr    <= '0;
      fpm_x  <= '0;
      fpm_y  <= '0;
      res_id <= '0;
    end else begin
      case (state)
        ARB: begin
          if (grantNow) begin
            fpm_x  <= opa[int'(gidx)*W +: W];
            fpm_y  <= opb[int'(gidx)*W +: W];
            res_id <= gidx;
            state  <= ISSUE;
          end
        end
        ISSUE: state <= BUSY;
        BUSY: begin
          if (fpm_state == FPM_POST) state <= RESULT;
        end
        RESULT: begin
          ptr   <= (res_id == IDW'(NREQ-1)) ? '0 : res_id + 1'b1;
          state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences
// and a randomized run against a round-robin scoreboard model.
module tb_fp_mult_arbiter;

  localparam int MBITS = 3;
  localparam int EBITS = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int W     = 8;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] opa;
  logic [NREQ*W-1:0] opb;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [W-1:0]      res_z;
  logic              fpm_start;
  logic [W-1:0]      fpm_x;
  logic [W-1:0]      fpm_y;
  logic [1:0]        fpmStateIn;

  logic [1:0] mulState = 2'd0;
  logic [7:0] mulX = 8'h00;
  logic [7:0] mulY = 8'h00;
  logic [7:0] mulZ = 8'h00;
  logic       freezeMul = 1'b0;
  logic       forceIllegal = 1'b0;
  int         cycleCnt = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expZ;
  } opVec_t;

  typedef struct {
    int         cyc;
    int         id;
    logic [7:0] z;
  } pend_t;

  fp_mult_arbiter #(.MBITS(MBITS), .EBITS(EBITS), .NREQ(NREQ), .IDW(IDW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .opa       (opa),
    .opb       (opb),
    .ack       (ack),
    .busy      (busy),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_z     (res_z),
    .fpm_start (fpm_start),
    .fpm_x     (fpm_x),
    .fpm_y     (fpm_y),
    .fpm_state (fpmStateIn),
    .fpm_z     (mulZ)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // 1-4-3 float multiply, bias 7, subnormals flushed, mantissa truncated.
  function automatic logic [7:0] fpMul(input logic [7:0] a, input logic [7:0] b);
    logic s;
    int ea, eb, ma, mb, e, prod, mant;
    bit aNan, bNan, aInf, bInf, aZero, bZero;
    s = a[7] ^ b[7];
    ea = int'(a[6:3]); eb = int'(b[6:3]);
    ma = int'(a[2:0]); mb = int'(b[2:0]);
    aNan = (ea == 15) && (ma != 0); bNan = (eb == 15) && (mb != 0);
    aInf = (ea == 15) && (ma == 0); bInf = (eb == 15) && (mb == 0);
    aZero = (ea == 0); bZero = (eb == 0);
    if (aNan || bNan || (aInf && bZero) || (bInf && aZero)) return 8'h7F;
    if (aInf || bInf) return {s, 7'h78};
    if (aZero || bZero) return {s, 7'h00};
    prod = (8 + ma) * (8 + mb);
    e = ea + eb - 7;
    if (prod >= 128) begin
      mant = (prod >> 4) & 7;
      e++;
    end else begin
      mant = (prod >> 3) & 7;
    end
    if (e >= 15) return {s, 7'h78};
    if (e <= 0) return {s, 7'h00};
    return {s, e[3:0], mant[2:0]};
  endfunction

  // Stand-in for the external non-pipelined multiplier.
  always @(posedge clock) begin
    if (!freezeMul) begin
      if (fpm_start) begin
        mulState <= 2'd1;
        mulX     <= fpm_x;
        mulY     <= fpm_y;
      end else if (mulState == 2'd1) begin
        mulState <= 2'd2;
      end else if (mulState == 2'd2) begin
        mulState <= 2'd0;
        mulZ     <= fpMul(mulX, mulY);
      end
    end
  end
  assign fpmStateIn = forceIllegal ? 2'd3 : mulState;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clock);
  endtask

  task automatic applyStimulus(input int id, input logic [7:0] a, input logic [7:0] b);
    opa[id*W +: W] = a;
    opb[id*W +: W] = b;
    req[id] = 1'b1;
  endtask

  task automatic resetPulse();
    reset_n = 1'b0;
    nextCycle();
    reset_n = 1'b1;
  endtask

  task automatic waitAck(input logic [3:0] expAck, input string name);
    int n;
    n = 0;
    midCycle();
    while (ack == '0 && n < 20) begin
      nextCycle();
      midCycle();
      n++;
    end
    checkOutput(name, ack, expAck);
  endtask

  task automatic waitResult(input int expId, input logic [7:0] expZ, input string name);
    int n;
    n = 0;
    midCycle();
    while (!res_valid && n < 20) begin
      nextCycle();
      midCycle();
      n++;
    end
    checkOutput({name, " valid"}, res_valid, 1);
    checkOutput({name, " id"}, res_id, expId);
    checkOutput({name, " z"}, res_z, expZ);
    nextCycle();
  endtask

  task automatic doOp(input int id, input logic [7:0] a, input logic [7:0] b, input logic [7:0] expZ);
    logic [3:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    applyStimulus(id, a, b);
    waitAck(oh, "op ack");
    nextCycle();
    req[id] = 1'b0;
    midCycle();
    checkOutput("op start", fpm_start, 1);
    nextCycle(); midCycle();
    checkOutput("op early valid", res_valid, 0);
    nextCycle(); midCycle();
    checkOutput("op early valid", res_valid, 0);
    nextCycle(); midCycle();
    checkOutput("op valid", res_valid, 1);
    checkOutput("op res_id", res_id, id);
    checkOutput("op res_z", res_z, expZ);
    checkOutput("op fpm_x hold", fpm_x, a);
    checkOutput("op fpm_y hold", fpm_y, b);
    nextCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    opVec_t vecs[6];
    pend_t  pq[$];
    int     prevT, seen3, seenAll, n, ptrM, lastGrant, now;
    int     cool[NREQ];
    logic [3:0] ackSeen, expAck;
    logic       expStart, expValid;

    reset_n = 1'b0;
    req = '1;
    opa = '0;
    opb = '0;
    nextCycle(); nextCycle();
    midCycle();
    checkOutput("reset ack", ack, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset res_valid", res_valid, 0);
    checkOutput("reset fpm_start", fpm_start, 0);
    checkOutput("reset fpm_x", fpm_x, 0);
    checkOutput("reset fpm_y", fpm_y, 0);
    checkOutput("reset res_id", res_id, 0);
    nextCycle();
    req = '0;
    reset_n = 1'b1;
    nextCycle();

    vecs[0] = '{2, 8'h38, 8'h40, 8'h40};
    vecs[1] = '{1, 8'h78, 8'h00, 8'h7F};
    vecs[2] = '{0, 8'hF8, 8'h38, 8'hF8};
    vecs[3] = '{3, 8'h68, 8'h68, 8'h78};
    vecs[4] = '{2, 8'h08, 8'h08, 8'h00};
    vecs[5] = '{1, 8'h3C, 8'h3C, 8'h41};
    foreach (vecs[i]) doOp(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].expZ);

    // Fairness: everybody requests continuously from reset.
    reset_n = 1'b0;
    for (int k = 0; k < NREQ; k++) applyStimulus(k, 8'($urandom), 8'($urandom));
    nextCycle();
    reset_n = 1'b1;
    prevT = 0;
    for (int g = 0; g < 5; g++) begin
      logic [3:0] oh;
      oh = '0;
      oh[g % NREQ] = 1'b1;
      waitAck(oh, "fair grant");
      if (g > 0) checkOutput("fair spacing", cycleCnt - prevT, 5);
      prevT = cycleCnt;
      nextCycle();
    end
    req = '0;
    repeat (8) nextCycle();

    // Withdrawn request pulsed while the multiplier is busy.
    applyStimulus(0, 8'h38, 8'h38);
    waitAck(4'b0001, "wd ack0");
    nextCycle(); req = '0;
    nextCycle(); req[3] = 1'b1;
    midCycle();
    checkOutput("wd ack busy", ack, 0);
    nextCycle(); req[3] = 1'b0;
    seen3 = 0; seenAll = 0;
    for (int c = 0; c < 10; c++) begin
      midCycle();
      checkOutput("wd ack idle", ack, 0);
      if (res_valid) begin
        seenAll++;
        if (res_id == 2'd3) seen3++;
      end
      nextCycle();
    end
    checkOutput("wd id3 results", seen3, 0);
    checkOutput("wd total results", seenAll, 1);

    // Illegal multiplier state 3 must keep the sequencer in BUSY.
    applyStimulus(1, 8'h40, 8'h40);
    waitAck(4'b0010, "ill ack");
    nextCycle(); req = '0;
    nextCycle();
    freezeMul = 1'b1; forceIllegal = 1'b1;
    for (int c = 0; c < 5; c++) begin
      midCycle();
      checkOutput("ill busy", busy, 1);
      checkOutput("ill res_valid", res_valid, 0);
      nextCycle();
    end
    freezeMul = 1'b0; forceIllegal = 1'b0;
    waitResult(1, 8'h48, "ill result");
    repeat (2) nextCycle();

    // Reset in the middle of an operation: orphan dropped, ptr back to 0.
    doOp(1, 8'h38, 8'h38, 8'h38);
    applyStimulus(2, 8'h40, 8'h40);
    waitAck(4'b0100, "rst ack2");
    nextCycle(); req = '0;
    nextCycle(); reset_n = 1'b0;
    midCycle();
    checkOutput("rst busy", busy, 0);
    checkOutput("rst fpm_x", fpm_x, 0);
    checkOutput("rst res_id", res_id, 0);
    nextCycle();
    reset_n = 1'b1;
    applyStimulus(1, 8'h40, 8'h38);
    applyStimulus(3, 8'h38, 8'h38);
    n = 0;
    midCycle();
    while (mulState != 2'd0 && n < 8) begin
      checkOutput("rst wait ack", ack, 0);
      checkOutput("rst orphan valid", res_valid, 0);
      nextCycle(); midCycle();
      n++;
    end
    checkOutput("rst orphan valid", res_valid, 0);
    checkOutput("rst regrant", ack, 4'b0010);
    nextCycle(); req = '0;
    waitResult(1, 8'h40, "rst result");
    repeat (6) nextCycle();

    // Randomized traffic against a round-robin scoreboard.
    resetPulse();
    ptrM = 0; lastGrant = -100; ackSeen = '0;
    for (int k = 0; k < NREQ; k++) cool[k] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (ackSeen[k]) begin
          req[k] = 1'b0;
          cool[k] = int'($urandom_range(0, 6));
        end else if (req[k]) begin
          if ($urandom_range(0, 15) == 0) req[k] = 1'b0;
        end else if (cool[k] > 0) begin
          cool[k]--;
        end else if ($urandom_range(0, 2) == 0) begin
          applyStimulus(k, 8'($urandom), 8'($urandom));
        end
      end
      midCycle();
      now = cycleCnt;
      expAck = '0;
      expStart = (now == lastGrant + 1);
      if (now - lastGrant >= 5 && req != '0) begin
        for (int i = 0; i < NREQ; i++) begin
          int k;
          k = (ptrM + i) % NREQ;
          if (req[k]) begin
            expAck[k] = 1'b1;
            pq.push_back('{now + 4, k, fpMul(opa[k*W +: W], opb[k*W +: W])});
            lastGrant = now;
            ptrM = (k + 1) % NREQ;
            break;
          end
        end
      end
      expValid = (pq.size() > 0) && (pq[0].cyc == now);
      checkOutput("rnd ack", ack, expAck);
      checkOutput("rnd start", fpm_start, expStart);
      checkOutput("rnd valid", res_valid, expValid);
      if (expValid) begin
        checkOutput("rnd res_id", res_id, pq[0].id);
        checkOutput("rnd res_z", res_z, pq[0].z);
        void'(pq.pop_front());
      end
      ackSeen = ack;
      nextCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
